// File: rtl/mips_write_monitor.sv
// Data-memory write-bus checker: loadable table of expected writes,
// ordered/unordered matching, ignore address and RUN watchdog.
module mips_write_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int ORDERED = 1,
  parameter int TIMEOUT = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       start,
  input  logic                       ign_en,
  input  logic [ADDR_W-1:0]          ign_addr,
  input  logic                       memwrite,
  input  logic [ADDR_W-1:0]          dataadr,
  input  logic [DATA_W-1:0]          writedata,
  output logic                       busy,
  output logic                       ld_full,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data,
  output logic [$clog2(DEPTH+1)-1:0] match_cnt
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  matched;
  logic [TW-1:0]     wd;
  logic [ADDR_W-1:0] tab_addr [DEPTH];
  logic [DATA_W-1:0] tab_data [DEPTH];

  logic          ld_ok;
  logic [CW-1:0] cnt_eff;
  logic [CW-1:0] mc_inc;
  logic [IW-1:0] widx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] hit_idx;
  logic          hit;
  logic          ign;
  logic          wd_hit;

  assign ld_ok   = (state == S_LOAD) && ld_valid && (cnt != FULL);
  assign cnt_eff = cnt + CW'(ld_ok);
  assign mc_inc  = match_cnt + CW'(1);
  assign widx    = cnt[IW-1:0];
  assign ptr     = match_cnt[IW-1:0];
  assign wd_hit  = (TIMEOUT > 0) && (wd == TO_LAST);

  // vld gates entries beyond the loaded count in both modes
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (ORDERED != 0) begin
      hit     = vld[ptr] && (tab_addr[ptr] == dataadr)
                && (tab_data[ptr] == writedata);
      hit_idx = ptr;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!hit && vld[i] && !matched[i]
            && (tab_addr[i] == dataadr)
            && (tab_data[i] == writedata)) begin
          hit     = 1'b1;
          hit_idx = IW'(i);
        end
      end
    end
  end

  assign ign = !hit && ign_en && (dataadr == ign_addr);

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      tab_addr[widx] <= ld_addr;
      tab_data[widx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      cnt       <= '0;
      vld       <= '0;
      matched   <= '0;
      match_cnt <= '0;
      wd        <= '0;
      fail_code <= 2'd0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (ld_ok) begin
            cnt       <= cnt_eff;
            vld[widx] <= 1'b1;
          end
          if (start) begin
            wd <= '0;
            if (cnt_eff == '0) begin
              state     <= S_FAIL;
              fail_code <= 2'd3;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (memwrite && hit) begin
            matched[hit_idx] <= 1'b1;
            match_cnt        <= mc_inc;
            wd               <= '0;
            if (mc_inc == cnt) state <= S_PASS;
          end else if (memwrite && ign) begin
            wd <= '0;
          end else if (memwrite) begin
            state     <= S_FAIL;
            fail_code <= 2'd1;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (wd_hit) begin
            state     <= S_FAIL;
            fail_code <= 2'd2;
            fail_addr <= '0;
            fail_data <= '0;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        S_PASS, S_FAIL: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_PASS) || (state == S_FAIL);
  assign pass    = (state == S_PASS);
  assign fail    = (state == S_FAIL);
  assign ld_full = (cnt == FULL);

endmodule

// File: tb/tb_mips_write_monitor.sv
// Scoreboard bench: ordered and unordered monitors side by side,
// expectations from a cycle-level reference model of the write rules.
module tb_mips_write_monitor;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int TO  = 20;
  localparam int CW  = $clog2(DEP+1);

  typedef struct {
    int          cyc;
    bit          ps;
    int          code;
    logic [31:0] fa;
    logic [31:0] fd;
    int          mc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic start = 1'b0;
  logic ign_en = 1'b0;
  logic [AW-1:0] ign_addr = '0;
  logic memwrite = 1'b0;
  logic [AW-1:0] dataadr = '0;
  logic [DW-1:0] writedata = '0;

  logic [1:0] busy_w, ld_full_w, done_w, pass_w, fail_w;
  logic [1:0][1:0]    fc_w;
  logic [1:0][AW-1:0] fa_w;
  logic [1:0][DW-1:0] fd_w;
  logic [1:0][CW-1:0] mc_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  bit [1:0] dq = 2'b00;

  int nld;
  logic [31:0] la[8];
  logic [31:0] lda[8];
  bit ie;
  logic [31:0] ia;
  bit wen[64];
  logic [31:0] wa[64];
  logic [31:0] wdv[64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_write_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ORDERED(1), .TIMEOUT(TO)
  ) u_ord (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .ign_en(ign_en), .ign_addr(ign_addr),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy_w[0]), .ld_full(ld_full_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .fail(fail_w[0]), .fail_code(fc_w[0]),
    .fail_addr(fa_w[0]), .fail_data(fd_w[0]), .match_cnt(mc_w[0])
  );

  mips_write_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ORDERED(0), .TIMEOUT(TO)
  ) u_uno (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .ign_en(ign_en), .ign_addr(ign_addr),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy_w[1]), .ld_full(ld_full_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .fail(fail_w[1]), .fail_code(fc_w[1]),
    .fail_addr(fa_w[1]), .fail_data(fd_w[1]), .match_cnt(mc_w[1])
  );

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
               nm, k, cyc, act, exp);
    end
  endtask

  // Reference: walk RUN cycles 1.. applying match/ignore/fail/timeout rules
  function automatic exp_t model(input bit ord);
    exp_t e;
    int n, got, idle;
    bit used[8];
    e.cyc = -1; e.ps = 0; e.code = 0; e.fa = 0; e.fd = 0; e.mc = 0;
    for (int i = 0; i < 8; i++) used[i] = 0;
    n = (nld < DEP) ? nld : DEP;
    if (n == 0) begin
      e.cyc = 0; e.code = 3;
      return e;
    end
    got = 0; idle = 0;
    for (int c = 1; c < 64; c++) begin
      if (wen[c]) begin
        int h;
        h = -1;
        if (ord) begin
          if (la[got] == wa[c] && lda[got] == wdv[c]) h = got;
        end else begin
          for (int i = 0; i < n; i++)
            if (h < 0 && !used[i] && la[i] == wa[c] && lda[i] == wdv[c])
              h = i;
        end
        if (h >= 0) begin
          used[h] = 1; got++; idle = 0;
          if (got == n) begin
            e.cyc = c; e.ps = 1; e.mc = got;
            return e;
          end
        end else if (ie && wa[c] == ia) begin
          idle = 0;
        end else begin
          e.cyc = c; e.code = 1; e.fa = wa[c]; e.fd = wdv[c]; e.mc = got;
          return e;
        end
      end else begin
        idle++;
        if (idle == TO) begin
          e.cyc = c; e.code = 2; e.mc = got;
          return e;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit have;
      have = 0;
      if (k == 0 && sb0.size() > 0) begin have = 1; e = sb0[0]; end
      if (k == 1 && sb1.size() > 0) begin have = 1; e = sb1[0]; end
      if (done_w[k] && !dq[k]) begin
        if (!have) begin
          checks++; errors++;
          $display("FAIL unexpected_done dut%0d cycle %0d: got 1 expected 0",
                   k, cyc);
        end else begin
          if (k == 0) void'(sb0.pop_front());
          else void'(sb1.pop_front());
          chk("done_cycle", k, cyc, e.cyc);
          chk("pass", k, pass_w[k], e.ps);
          chk("fail", k, fail_w[k], !e.ps);
          chk("fail_code", k, fc_w[k], e.code);
          chk("fail_addr", k, fa_w[k], e.fa);
          chk("fail_data", k, fd_w[k], e.fd);
          chk("match_cnt", k, mc_w[k], e.mc);
        end
      end else if (have && cyc > e.cyc) begin
        checks++; errors++;
        $display("FAIL done_late dut%0d cycle %0d: got 0 expected done at %0d",
                 k, cyc, e.cyc);
        if (k == 0) void'(sb0.pop_front());
        else void'(sb1.pop_front());
      end
      dq[k] = done_w[k];
    end
  end

  task automatic clear_sched();
    nld = 0; ie = 0; ia = 0;
    for (int i = 0; i < 8; i++) begin la[i] = 0; lda[i] = 0; end
    for (int c = 0; c < 64; c++) begin wen[c] = 0; wa[c] = 0; wdv[c] = 0; end
  endtask

  task automatic add_ld(input logic [31:0] a, input logic [31:0] d);
    la[nld] = a; lda[nld] = d; nld++;
  endtask

  task automatic add_wr(input int c, input logic [31:0] a,
                        input logic [31:0] d);
    wen[c] = 1; wa[c] = a; wdv[c] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; ld_valid = 0; start = 0; memwrite = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic run_test(input bit sw);
    exp_t eo, eu, e;
    int s, m, ncyc;
    eo = model(1);
    eu = model(0);
    m = (eo.cyc > eu.cyc) ? eo.cyc : eu.cyc;
    ncyc = m + 2;
    do_reset();
    ign_en = ie; ign_addr = ia;
    for (int k = 0; k < 2; k++) begin
      chk("reset_status", k,
          {busy_w[k], done_w[k], pass_w[k], fail_w[k],
           ld_full_w[k], fc_w[k], mc_w[k]}, 0);
      chk("reset_capture", k, fa_w[k] | fd_w[k], 0);
    end
    for (int i = 0; i < nld; i++) begin
      ld_valid = 1; ld_addr = la[i]; ld_data = lda[i];
      if (!(sw && i == nld - 1)) begin
        @(posedge clk); #1;
        ld_valid = 0;
      end
    end
    if (!sw || nld == 0) begin
      ld_valid = 0;
      for (int k = 0; k < 2; k++)
        chk("ld_full", k, ld_full_w[k], (nld >= DEP) ? 1 : 0);
    end
    s = cyc;
    eo.cyc += s + 1;
    eu.cyc += s + 1;
    sb0.push_back(eo);
    sb1.push_back(eu);
    start = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 0; ld_valid = 0;
      memwrite = wen[c]; dataadr = wa[c]; writedata = wdv[c];
    end
    @(posedge clk); #1;
    memwrite = 0;
    repeat (2) @(posedge clk);
    #1;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_pending cycle %0d: got %0d entries expected 0",
               cyc, sb0.size() + sb1.size());
      sb0.delete(); sb1.delete();
    end
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? eo : eu;
      chk("sticky_status", k, {pass_w[k], fail_w[k], done_w[k], fc_w[k]},
          {e.ps, !e.ps, 1'b1, 2'(e.code)});
      chk("sticky_match_cnt", k, mc_w[k], e.mc);
      chk("sticky_fail_addr", k, fa_w[k], e.fa);
      chk("sticky_fail_data", k, fd_w[k], e.fd);
    end
  endtask

  task automatic reset_mid_run();
    do_reset();
    ign_en = 0;
    ld_valid = 1; ld_addr = 0; ld_data = 1;
    @(posedge clk); #1;
    ld_addr = 4; ld_data = 2;
    @(posedge clk); #1;
    ld_valid = 0; start = 1;
    @(posedge clk); #1;
    start = 0; memwrite = 1; dataadr = 0; writedata = 1;
    @(posedge clk); #1;
    memwrite = 0;
    for (int k = 0; k < 2; k++) begin
      chk("midrun_busy", k, busy_w[k], 1);
      chk("midrun_match_cnt", k, mc_w[k], 1);
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      chk("after_reset_busy", k, busy_w[k], 0);
      chk("after_reset_match_cnt", k, mc_w[k], 0);
      chk("after_reset_status", k,
          {pass_w[k], fail_w[k], done_w[k], fc_w[k]}, 0);
    end
  endtask

  task automatic gen_random();
    int n, nxt, len, r, idx;
    clear_sched();
    nld = $urandom_range(0, 5);
    if (nld == 0 && $urandom_range(0, 3) != 0) nld = 1;
    for (int i = 0; i < nld; i++) begin
      la[i] = 4 * $urandom_range(0, 7);
      lda[i] = $urandom_range(0, 3);
    end
    ie = 1'($urandom_range(0, 1));
    ia = 4 * $urandom_range(0, 7);
    n = (nld < DEP) ? nld : DEP;
    nxt = 0;
    len = $urandom_range(3, 25);
    for (int c = 1; c <= len; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 9);
        if (r < 6 && n > 0) begin
          idx = (r < 4) ? (nxt % n) : $urandom_range(0, n - 1);
          nxt++;
          add_wr(c, la[idx], lda[idx]);
        end else if (r < 8) begin
          add_wr(c, ia, $urandom);
        end else begin
          add_wr(c, 4 * $urandom_range(0, 7), $urandom_range(0, 3));
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout cycle %0d: simulation did not finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    clear_sched();
    add_ld(84, 7); ie = 1; ia = 80;
    add_wr(1, 80, 3); add_wr(2, 80, 9); add_wr(3, 84, 7);
    run_test(0);

    clear_sched();
    add_ld(84, 7);
    add_wr(1, 84, 6); add_wr(2, 84, 7);
    run_test(0);

    clear_sched();
    add_ld(0, 1); add_ld(4, 2);
    add_wr(1, 4, 2); add_wr(2, 0, 1);
    run_test(0);

    clear_sched();
    add_ld(0, 1); add_ld(4, 2);
    add_wr(1, 4, 2); add_wr(2, 4, 2);
    run_test(0);

    clear_sched();
    add_ld(8, 5);
    run_test(0);

    clear_sched();
    add_ld(8, 5); ie = 1; ia = 80;
    add_wr(15, 80, 0);
    run_test(0);

    clear_sched();
    run_test(0);

    clear_sched();
    for (int i = 0; i < 5; i++) add_ld(16 + 4 * i, i);
    for (int i = 0; i < 4; i++) add_wr(i + 1, 16 + 4 * i, i);
    run_test(0);

    clear_sched();
    add_ld(12, 5);
    add_wr(2, 12, 5);
    run_test(1);

    clear_sched();
    add_ld(84, 7); ie = 1; ia = 84;
    add_wr(1, 84, 7);
    run_test(0);

    reset_mid_run();
    clear_sched();
    add_ld(0, 1); add_ld(4, 2);
    add_wr(1, 0, 1); add_wr(3, 4, 2);
    run_test(0);

    for (int t = 0; t < 40; t++) begin
      gen_random();
      run_test(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
